// File: rtl/bsg_mcl_axil_rx_reader_if.sv
// ---------------------------------------------------------------------------
// bsg_mcl_axil_rx_reader_if
// AXI4-Lite read-channel bundle (AR + R) between the host interconnect and
// the manycore-link RX reader.
//   araddr  : AR address            (master -> slave)
//   arvalid : AR valid              (master -> slave)
//   arready : AR ready              (slave  -> master)
//   rdata   : R data                (slave  -> master)
//   rresp   : R response            (slave  -> master)
//   rvalid  : R valid               (slave  -> master)
//   rready  : R ready               (master -> slave)
// ---------------------------------------------------------------------------
interface bsg_mcl_axil_rx_reader_if #(
   parameter int addr_width_p = 32,
   parameter int data_width_p = 32
);
   logic [addr_width_p-1:0] araddr;
   logic                    arvalid;
   logic                    arready;
   logic [data_width_p-1:0] rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output araddr, arvalid, rready,
      input  arready, rdata, rresp, rvalid
   );

   modport slave (
      input  araddr, arvalid, rready,
      output arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/bsg_mcl_axil_rx_reader.sv
// ---------------------------------------------------------------------------
// bsg_mcl_axil_rx_reader
// AXI4-Lite slave read front end for the manycore-link RX path. Exposes the
// RX FIFO head word as a data-pop register and the FIFO occupancy count as a
// read-only occupancy register. One outstanding read at a time.
// Ports:
//   clk_i        : clock
//   reset_i      : synchronous active-high reset
//   s_axil       : AXI-Lite read channel (slave modport)
//   fifo_data_i  : RX FIFO head word
//   fifo_v_i     : RX FIFO head word valid
//   fifo_yumi_o  : pop strobe, only ever asserted together with fifo_v_i
//   credits_i    : RX FIFO occupancy count
// Also contains bsg_mcl_axil_rx_reader_chk, a simulation-only property
// checker instantiated by the top.
// ---------------------------------------------------------------------------
module bsg_mcl_axil_rx_reader_chk #(
   parameter int                          axil_addr_width_p = 32,
   parameter int                          axil_data_width_p = 32,
   parameter int                          credits_width_p   = 8,
   parameter logic [axil_addr_width_p-1:0] fifo_ofs_p       = axil_addr_width_p'(32'h0),
   parameter logic [axil_addr_width_p-1:0] count_ofs_p      = axil_addr_width_p'(32'h4)
) (
   input logic i_clk,
   input logic i_reset,
   input logic i_fifo_v,
   input logic i_fifo_yumi
);
   localparam logic [axil_addr_width_p-1:0] lp_word_mask =
      {{(axil_addr_width_p-2){1'b1}}, 2'b00};

   a_credits_fit: assert property (@(posedge i_clk)
      (credits_width_p <= axil_data_width_p));

   // Both registers must decode to distinct words, the byte lane is ignored.
   a_ofs_distinct: assert property (@(posedge i_clk)
      ((fifo_ofs_p & lp_word_mask) != (count_ofs_p & lp_word_mask)));

   a_yumi_needs_v: assert property (@(posedge i_clk) disable iff (i_reset)
      (i_fifo_yumi |-> i_fifo_v));
endmodule

module bsg_mcl_axil_rx_reader #(
   parameter int                          axil_addr_width_p = 32,
   parameter int                          axil_data_width_p = 32,
   parameter int                          credits_width_p   = 8,
   parameter logic [axil_addr_width_p-1:0] base_addr_p      = axil_addr_width_p'(32'h0),
   parameter logic [axil_addr_width_p-1:0] fifo_ofs_p       = axil_addr_width_p'(32'h0),
   parameter logic [axil_addr_width_p-1:0] count_ofs_p      = axil_addr_width_p'(32'h4)
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   bsg_mcl_axil_rx_reader_if.slave       s_axil,
   input  logic [axil_data_width_p-1:0]  fifo_data_i,
   input  logic                          fifo_v_i,
   output logic                          fifo_yumi_o,
   input  logic [credits_width_p-1:0]    credits_i
);
   localparam logic [1:0] lp_resp_okay   = 2'b00;
   localparam logic [1:0] lp_resp_slverr = 2'b10;
   localparam logic [1:0] lp_resp_decerr = 2'b11;

   // Clears off[1:0] so any byte address within a word selects that word.
   localparam logic [axil_addr_width_p-1:0] lp_word_mask =
      {{(axil_addr_width_p-2){1'b1}}, 2'b00};

   typedef enum logic [0:0] {
      e_idle = 1'b0,
      e_resp = 1'b1
   } state_e;

   state_e                         r_state;
   state_e                         w_state_next;
   logic [axil_data_width_p-1:0]   r_rdata;
   logic [1:0]                     r_rresp;

   logic                           w_arready;
   logic                           w_ar_hs;
   logic                           w_r_hs;
   logic [axil_addr_width_p-1:0]   w_off;
   logic                           w_hit_fifo;
   logic                           w_hit_count;
   logic [axil_data_width_p-1:0]   w_credits_ext;
   logic [axil_data_width_p-1:0]   w_rdata_next;
   logic [1:0]                     w_rresp_next;
   logic                           w_yumi;

   // arready is gated by reset so no AR can be accepted while reset is held.
   assign w_arready   = (r_state == e_idle) && !reset_i;
   assign w_ar_hs     = s_axil.arvalid && w_arready;
   assign w_r_hs      = (r_state == e_resp) && s_axil.rready;

   assign w_off       = s_axil.araddr - base_addr_p;
   assign w_hit_fifo  = ((w_off ^ fifo_ofs_p)  & lp_word_mask) == '0;
   assign w_hit_count = ((w_off ^ count_ofs_p) & lp_word_mask) == '0;

   // Zero-extend the occupancy count to the bus width.
   always_comb begin
      w_credits_ext                      = '0;
      w_credits_ext[credits_width_p-1:0] = credits_i;
   end

   // Address decode: response payload for the current AR and the pop strobe.
   always_comb begin
      w_rdata_next = '0;
      w_rresp_next = lp_resp_decerr;
      w_yumi       = 1'b0;
      if (w_hit_fifo) begin
         if (fifo_v_i) begin
            w_rdata_next = fifo_data_i;
            w_rresp_next = lp_resp_okay;
            w_yumi       = w_ar_hs;
         end else begin
            w_rdata_next = '0;
            w_rresp_next = lp_resp_slverr;
            w_yumi       = 1'b0;
         end
      end else if (w_hit_count) begin
         w_rdata_next = w_credits_ext;
         w_rresp_next = lp_resp_okay;
         w_yumi       = 1'b0;
      end else begin
         w_rdata_next = '0;
         w_rresp_next = lp_resp_decerr;
         w_yumi       = 1'b0;
      end
   end

   // Next-state logic for the single-outstanding-read FSM.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         e_idle: begin
            if (w_ar_hs) begin
               w_state_next = e_resp;
            end else begin
               w_state_next = e_idle;
            end
         end
         e_resp: begin
            if (w_r_hs) begin
               w_state_next = e_idle;
            end else begin
               w_state_next = e_resp;
            end
         end
         default: w_state_next = e_idle;
      endcase
   end

   // State register; reset drops any pending response.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= e_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Response payload captured at the AR handshake and held through RESP.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_rdata <= '0;
         r_rresp <= lp_resp_okay;
      end else if (w_ar_hs) begin
         r_rdata <= w_rdata_next;
         r_rresp <= w_rresp_next;
      end
   end

   assign s_axil.arready = w_arready;
   assign s_axil.rvalid  = (r_state == e_resp);
   assign s_axil.rdata   = r_rdata;
   assign s_axil.rresp   = r_rresp;
   assign fifo_yumi_o    = w_yumi;

   bsg_mcl_axil_rx_reader_chk #(
      .axil_addr_width_p (axil_addr_width_p),
      .axil_data_width_p (axil_data_width_p),
      .credits_width_p   (credits_width_p),
      .fifo_ofs_p        (fifo_ofs_p),
      .count_ofs_p       (count_ofs_p)
   ) u_chk (
      .i_clk       (clk_i),
      .i_reset     (reset_i),
      .i_fifo_v    (fifo_v_i),
      .i_fifo_yumi (fifo_yumi_o)
   );
endmodule

// File: tb/tb_bsg_mcl_axil_rx_reader.sv
// ---------------------------------------------------------------------------
// tb_bsg_mcl_axil_rx_reader
// Directed bench for the AXI-Lite RX reader: reset, pop, empty pop, count,
// decode error, backpressure, back-to-back drain and reset during RESP.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// (registered) or 1ns after an input change (combinational pop strobe).
// ---------------------------------------------------------------------------
module tb_bsg_mcl_axil_rx_reader;
   localparam logic [31:0] lp_base = 32'h4000_1000;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic [31:0] fifo_data_i = 32'h0;
   logic        fifo_v_i = 1'b0;
   logic        fifo_yumi_o;
   logic [7:0]  credits_i = 8'h0;

   int          n_pass = 0;
   int          n_total = 0;
   int          cyc = 0;
   logic [31:0] fifo_q[$];

   bsg_mcl_axil_rx_reader_if #(.addr_width_p(32), .data_width_p(32)) axil_if ();

   bsg_mcl_axil_rx_reader #(
      .axil_addr_width_p (32),
      .axil_data_width_p (32),
      .credits_width_p   (8),
      .base_addr_p       (lp_base),
      .fifo_ofs_p        (32'h0),
      .count_ofs_p       (32'h4)
   ) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .s_axil      (axil_if),
      .fifo_data_i (fifo_data_i),
      .fifo_v_i    (fifo_v_i),
      .fifo_yumi_o (fifo_yumi_o),
      .credits_i   (credits_i)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc++;

   // RX FIFO model: pop on yumi, present the new head shortly after the edge.
   always @(posedge clk_i) begin
      if (fifo_yumi_o && fifo_q.size() > 0) fifo_q.delete(0);
      #1;
      fifo_v_i    = (fifo_q.size() > 0);
      fifo_data_i = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
   end

   // Queue a word and let the FIFO model present it before the next AR.
   task automatic push_word(input logic [31:0] w);
      fifo_q.push_back(w);
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   // Issue one AR (entered on a falling edge, rready assumed high) and return
   // what was observed; leaves the caller on the falling edge inside RESP.
   task automatic ar_read(input logic [31:0] addr, output logic ar_ok,
                          output logic yumi, output logic rv,
                          output logic [31:0] d, output logic [1:0] r,
                          output int issue_cyc);
      int n;
      n = 0;
      while (!axil_if.arready && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      ar_ok = axil_if.arready;
      axil_if.araddr  = addr;
      axil_if.arvalid = 1'b1;
      issue_cyc = cyc;
      #1;
      yumi = fifo_yumi_o;
      @(posedge clk_i);
      #1;
      axil_if.arvalid = 1'b0;
      @(negedge clk_i);
      rv = axil_if.rvalid;
      d  = axil_if.rdata;
      r  = axil_if.rresp;
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      axil_if.rready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         n_total++;
         if (axil_if.arready !== 1'b0) $display("FAIL reset_arready: got %b want 0", axil_if.arready);
         else n_pass++;
         n_total++;
         if (axil_if.rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", axil_if.rvalid);
         else n_pass++;
         n_total++;
         if (fifo_yumi_o !== 1'b0) $display("FAIL reset_yumi: got %b want 0", fifo_yumi_o);
         else n_pass++;
      end
      n_total++;
      if (axil_if.rdata !== 32'h0 || axil_if.rresp !== 2'b00)
         $display("FAIL reset_rdata: got %h/%b want 00000000/00", axil_if.rdata, axil_if.rresp);
      else n_pass++;
      reset_i = 1'b0;
      #1;
      n_total++;
      if (axil_if.arready !== 1'b1) $display("FAIL post_reset_arready: got %b want 1", axil_if.arready);
      else n_pass++;
   endtask

   task automatic test_pop();
      logic ok, y, rv; logic [31:0] d; logic [1:0] r; int c;
      push_word(32'hCAFE_0001);
      ar_read(lp_base + 32'h0, ok, y, rv, d, r, c);
      n_total++;
      if ({ok, y, rv} !== 3'b111) $display("FAIL pop_handshake: got arready/yumi/rvalid=%b want 111", {ok, y, rv});
      else n_pass++;
      n_total++;
      if (d !== 32'hCAFE_0001 || r !== 2'b00) $display("FAIL pop_data: got %h/%b want cafe0001/00", d, r);
      else n_pass++;
      n_total++;
      if (fifo_yumi_o !== 1'b0) $display("FAIL pop_yumi_one_cycle: got %b want 0", fifo_yumi_o);
      else n_pass++;
   endtask

   task automatic test_empty_pop();
      logic ok, y, rv; logic [31:0] d; logic [1:0] r; int c;
      ar_read(lp_base + 32'h0, ok, y, rv, d, r, c);
      n_total++;
      if ({ok, y, rv} !== 3'b101) $display("FAIL empty_handshake: got arready/yumi/rvalid=%b want 101", {ok, y, rv});
      else n_pass++;
      n_total++;
      if (d !== 32'h0 || r !== 2'b10) $display("FAIL empty_data: got %h/%b want 00000000/10", d, r);
      else n_pass++;
   endtask

   task automatic test_count();
      logic ok, y, rv; logic [31:0] d; logic [1:0] r; int c;
      logic [31:0] ofs [2];
      ofs[0] = 32'h4;
      ofs[1] = 32'h6;
      credits_i = 8'd5;
      push_word(32'h1234_5678);
      for (int i = 0; i < 2; i++) begin
         ar_read(lp_base + ofs[i], ok, y, rv, d, r, c);
         n_total++;
         if ({ok, y, rv} !== 3'b101) $display("FAIL count_handshake_%0d: got %b want 101", i, {ok, y, rv});
         else n_pass++;
         n_total++;
         if (d !== 32'd5 || r !== 2'b00) $display("FAIL count_data_%0d: got %h/%b want 00000005/00", i, d, r);
         else n_pass++;
      end
      credits_i = 8'hFF;
      ar_read(lp_base + 32'h4, ok, y, rv, d, r, c);
      n_total++;
      if (d !== 32'h0000_00FF || y !== 1'b0) $display("FAIL count_max: got %h yumi %b want 000000ff yumi 0", d, y);
      else n_pass++;
      // Drain the word that the count reads must have left in place.
      ar_read(lp_base + 32'h0, ok, y, rv, d, r, c);
      n_total++;
      if (d !== 32'h1234_5678 || y !== 1'b1) $display("FAIL count_no_pop: got %h yumi %b want 12345678 yumi 1", d, y);
      else n_pass++;
   endtask

   task automatic test_decerr();
      logic ok, y, rv; logic [31:0] d; logic [1:0] r; int c;
      logic [31:0] addrs [2];
      addrs[0] = lp_base + 32'h8;
      addrs[1] = lp_base - 32'h4;
      push_word(32'hDEAD_BEEF);
      for (int i = 0; i < 2; i++) begin
         ar_read(addrs[i], ok, y, rv, d, r, c);
         n_total++;
         if ({y, rv} !== 2'b01 || d !== 32'h0 || r !== 2'b11)
            $display("FAIL decerr_%0d: got yumi/rvalid=%b data %h resp %b want 01 00000000 11", i, {y, rv}, d, r);
         else n_pass++;
      end
      ar_read(lp_base + 32'h2, ok, y, rv, d, r, c);
      n_total++;
      if (d !== 32'hDEAD_BEEF || y !== 1'b1) $display("FAIL decerr_no_pop: got %h yumi %b want deadbeef yumi 1", d, y);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic ok, y, rv; logic [31:0] d; logic [1:0] r; int c, prev_c;
      logic [31:0] words [5];
      for (int i = 0; i < 5; i++) words[i] = 32'hB0B0_0000 + 32'(i);
      @(negedge clk_i);
      for (int i = 0; i < 5; i++) fifo_q.push_back(words[i]);
      @(posedge clk_i);
      @(negedge clk_i);
      axil_if.rready  = 1'b0;
      axil_if.araddr  = lp_base;
      axil_if.arvalid = 1'b1;
      #1;
      n_total++;
      if (fifo_yumi_o !== 1'b1) $display("FAIL bp_first_yumi: got %b want 1", fifo_yumi_o);
      else n_pass++;
      // arvalid stays high to tempt a second pop while R is stalled.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         #1;
         n_total++;
         if (axil_if.rvalid !== 1'b1 || axil_if.rdata !== words[0] || axil_if.rresp !== 2'b00 ||
             axil_if.arready !== 1'b0 || fifo_yumi_o !== 1'b0)
            $display("FAIL bp_hold_%0d: got rvalid %b data %h resp %b arready %b yumi %b want 1 %h 00 0 0",
                     i, axil_if.rvalid, axil_if.rdata, axil_if.rresp, axil_if.arready, fifo_yumi_o, words[0]);
         else n_pass++;
      end
      axil_if.arvalid = 1'b0;
      axil_if.rready  = 1'b1;
      @(negedge clk_i);
      prev_c = 0;
      for (int i = 1; i < 5; i++) begin
         ar_read(lp_base, ok, y, rv, d, r, c);
         n_total++;
         if ({ok, y, rv} !== 3'b111 || d !== words[i] || r !== 2'b00)
            $display("FAIL drain_%0d: got %b data %h resp %b want 111 %h 00", i, {ok, y, rv}, d, r, words[i]);
         else n_pass++;
         if (i > 1) begin
            n_total++;
            if (c - prev_c !== 2) $display("FAIL drain_rate_%0d: got %0d cycles want 2", i, c - prev_c);
            else n_pass++;
         end
         prev_c = c;
      end
      @(negedge clk_i);
      n_total++;
      if (fifo_q.size() !== 0) $display("FAIL drain_empty: got %0d words left want 0", fifo_q.size());
      else n_pass++;
   endtask

   task automatic test_reset_in_resp();
      credits_i = 8'd7;
      axil_if.rready  = 1'b0;
      axil_if.araddr  = lp_base + 32'h4;
      axil_if.arvalid = 1'b1;
      @(posedge clk_i);
      #1;
      axil_if.arvalid = 1'b0;
      @(negedge clk_i);
      n_total++;
      if (axil_if.rvalid !== 1'b1 || axil_if.rdata !== 32'd7)
         $display("FAIL rst_resp_pre: got rvalid %b data %h want 1 00000007", axil_if.rvalid, axil_if.rdata);
      else n_pass++;
      reset_i = 1'b1;
      @(negedge clk_i);
      reset_i = 1'b0;
      axil_if.rready = 1'b1;
      #1;
      n_total++;
      if (axil_if.rvalid !== 1'b0 || axil_if.rdata !== 32'h0 || axil_if.arready !== 1'b1)
         $display("FAIL rst_resp_post: got rvalid %b data %h arready %b want 0 00000000 1",
                  axil_if.rvalid, axil_if.rdata, axil_if.arready);
      else n_pass++;
   endtask

   initial begin
      axil_if.araddr  = 32'h0;
      axil_if.arvalid = 1'b0;
      axil_if.rready  = 1'b1;
      test_reset();
      @(negedge clk_i);
      test_pop();
      test_empty_pop();
      test_count();
      test_decerr();
      test_back_to_back();
      @(negedge clk_i);
      test_reset_in_resp();
      repeat (2) @(negedge clk_i);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no completion want finish before 100000ns");
      $fatal(1);
   end
endmodule
